// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [XLEN_DEF-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement negate; doubles as absolute value when neg is the sign bit.
module muldiv_sign_adj #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes.
// Optional MULDIV_EARLY_OUT_EN: multiplies with a zero operand finish in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] ru1,
    input  logic [XLEN-1:0] ru2,
    input  logic [4:0]      rd_i,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_o,
    output logic            ruwr_o
);

    localparam int DXLEN = 2 * XLEN;
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);
    localparam logic [XLEN-1:0] DIV0_Q = XLEN'($signed(DIV_BY_ZERO_Q));
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state;
    op_e              op_q;
    logic [DXLEN-1:0] acc;
    logic [XLEN-1:0]  b_q;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, rneg_q, special_q;
    logic [XLEN-1:0]  special_res_q;

    op_e             op_in;
    logic            signed_a, signed_b, a_neg, b_neg, is_div, want_rem;
    logic            div_zero, div_ovf, mul_zero, special_in;
    logic [XLEN-1:0] a_mag, b_mag, special_val;

    assign op_in    = op_e'(funct3);
    assign is_div   = funct3[2];
    assign want_rem = funct3[1];
    assign signed_a = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV) || (op_in == OP_REM);
    assign signed_b = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                      (op_in == OP_DIV) || (op_in == OP_REM);
    assign a_neg    = signed_a && ru1[XLEN-1];
    assign b_neg    = signed_b && ru2[XLEN-1];

    muldiv_sign_adj #(.W(XLEN)) u_abs_a (.value(ru1), .neg(a_neg), .out(a_mag));
    muldiv_sign_adj #(.W(XLEN)) u_abs_b (.value(ru2), .neg(b_neg), .out(b_mag));

    assign div_zero = is_div && (ru2 == '0);
    assign div_ovf  = is_div && signed_a && (ru1 == MIN_NEG) && (ru2 == '1);
`ifdef MULDIV_EARLY_OUT_EN
    assign mul_zero = !is_div && ((ru1 == '0) || (ru2 == '0));
`else
    assign mul_zero = 1'b0;
`endif
    assign special_in = div_zero || div_ovf || mul_zero;

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = want_rem ? ru1 : DIV0_Q;
        else if (div_ovf)
            special_val = want_rem ? '0 : MIN_NEG;
    end

    // One iteration step of each algorithm; acc = {upper half, lower half}
    logic [XLEN:0]    mul_sum;
    logic [DXLEN-1:0] mul_next, div_next;
    logic [XLEN+1:0]  div_diff;
    logic [XLEN-1:0]  rem_new;

    always_comb begin
        mul_sum  = {1'b0, acc[DXLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_diff = {1'b0, acc[DXLEN-1:XLEN], acc[XLEN-1]} - {2'b00, b_q};
        rem_new  = div_diff[XLEN+1] ? {acc[DXLEN-2:XLEN], acc[XLEN-1]} : div_diff[XLEN-1:0];
        div_next = {rem_new, acc[XLEN-2:0], ~div_diff[XLEN+1]};
    end

    logic [DXLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quot_fix, rem_fix, final_res;

    muldiv_sign_adj #(.W(DXLEN)) u_fix_prod (.value(acc),             .neg(neg_q),  .out(prod_fix));
    muldiv_sign_adj #(.W(XLEN))  u_fix_quot (.value(acc[XLEN-1:0]),   .neg(neg_q),  .out(quot_fix));
    muldiv_sign_adj #(.W(XLEN))  u_fix_rem  (.value(acc[DXLEN-1:XLEN]), .neg(rneg_q), .out(rem_fix));

    always_comb begin
        final_res = '0;
        if (special_q)
            final_res = special_res_q;
        else if (state == DIV)
            final_res = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_fix : quot_fix;
        else
            final_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[DXLEN-1:XLEN];
    end

    // Special cases preload cnt=LAST so they finish on the very next edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            op_q          <= OP_MUL;
            acc           <= '0;
            b_q           <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            rneg_q        <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            rd_o          <= '0;
            ruwr_o        <= 1'b0;
        end else begin
            done   <= 1'b0;
            ruwr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        op_q          <= op_in;
                        rd_o          <= rd_i;
                        b_q           <= b_mag;
                        acc           <= {{XLEN{1'b0}}, a_mag};
                        neg_q         <= a_neg ^ b_neg;
                        rneg_q        <= a_neg;
                        special_q     <= special_in;
                        special_res_q <= special_val;
                        cnt           <= special_in ? LAST : '0;
                        state         <= is_div ? DIV : MUL;
                    end
                end
                MUL, DIV: begin
                    if (cnt == LAST) begin
                        result <= final_res;
                        done   <= 1'b1;
                        ruwr_o <= (rd_o != 5'd0);
                        busy   <= 1'b0;
                        state  <= FIN;
                    end else begin
                        acc <= (state == MUL) ? mul_next : div_next;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expectations, a negedge monitor checks done.
// Honours MULDIV_EARLY_OUT_EN for the zero-operand multiply latency.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ru1, ru2;
    logic [4:0]      rd_i;
    logic            busy, done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_o;
    logic            ruwr_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        int          lat;
        time         t0;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   seen_lat;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .ru1(ru1), .ru2(ru2), .rd_i(rd_i),
        .busy(busy), .done(done), .result(result), .rd_o(rd_o), .ruwr_o(ruwr_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Waits for IDLE, issues one request and records the accepting edge time
    task automatic applyStimulus(input string name, input op_e f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_res, input int exp_lat, input bit push);
        int n = 0;
        time t0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " idle wait"}, 64'(busy || done), 64'(0));
        start  = 1'b1;
        funct3 = f;
        ru1    = a;
        ru2    = b;
        rd_i   = rd;
        @(posedge clk);
        t0 = $time;
        if (push) sbq.push_back('{exp_res, rd, (rd != 5'd0), exp_lat, t0, name});
        #1;
        start = 1'b0;
        checkOutput({name, " busy after accept"}, 64'(busy), 64'(1));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected done", 64'(done), 64'(0));
            end else begin
                cur = sbq.pop_front();
                seen_lat = int'(($time - 5 - cur.t0) / 10);
                checkOutput({cur.name, " result"}, 64'(result), 64'(cur.res));
                checkOutput({cur.name, " rd_o"}, 64'(rd_o), 64'(cur.rd));
                checkOutput({cur.name, " ruwr_o"}, 64'(ruwr_o), 64'(cur.wr));
                checkOutput({cur.name, " latency"}, 64'(seen_lat), 64'(cur.lat));
            end
        end else if (ruwr_o) begin
            checkOutput("ruwr_o without done", 64'(ruwr_o), 64'(0));
        end
    end

    initial begin
        int n;
        int early_lat;
`ifdef MULDIV_EARLY_OUT_EN
        early_lat = 1;
`else
        early_lat = 33;
`endif
        rst = 1'b0; start = 1'b0; funct3 = '0; ru1 = '0; ru2 = '0; rd_i = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset done", 64'(done), 64'(0));
        checkOutput("reset result", 64'(result), 64'(0));
        checkOutput("reset rd_o", 64'(rd_o), 64'(0));
        checkOutput("reset ruwr_o", 64'(ruwr_o), 64'(0));
        rst = 1'b1;

        applyStimulus("MUL 7*-3",        OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 1'b1);
        applyStimulus("MULH min*min",    OP_MULH,   32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 33, 1'b1);
        applyStimulus("MULHU max*max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33, 1'b1);
        applyStimulus("MULHSU -1*2",     OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd3, 32'hFFFFFFFF, 33, 1'b1);
        applyStimulus("DIV -7/2",        OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFD, 33, 1'b1);
        applyStimulus("REM -7/2",        OP_REM,    32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 33, 1'b1);
        applyStimulus("DIVU 100/7",      OP_DIVU,   32'd100,      32'd7,        5'd7, 32'd14,       33, 1'b1);
        applyStimulus("REMU 100/7",      OP_REMU,   32'd100,      32'd7,        5'd8, 32'd2,        33, 1'b1);
        applyStimulus("DIVU 5/0",        OP_DIVU,   32'd5,        32'd0,        5'd9, 32'hFFFFFFFF, 1,  1'b1);
        applyStimulus("REM 5/0",         OP_REM,    32'd5,        32'd0,        5'd10, 32'd5,       1,  1'b1);
        applyStimulus("DIV overflow",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1, 1'b1);
        applyStimulus("REM overflow",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0,       1,  1'b1);
        applyStimulus("DIVU 9/3 rd0",    OP_DIVU,   32'd9,        32'd3,        5'd0, 32'd3,        33, 1'b1);
        applyStimulus("MUL 0*0x12345",   OP_MUL,    32'd0,        32'h00012345, 5'd13, 32'd0, early_lat, 1'b1);

        // A second request while busy must not disturb the operation in flight
        applyStimulus("MUL 6*7 busy",    OP_MUL,    32'd6,        32'd7,        5'd14, 32'd42,      33, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; funct3 = OP_DIVU; ru1 = 32'd100; ru2 = 32'd100; rd_i = 5'd20;
        repeat (4) @(negedge clk);
        start = 1'b0;
        checkOutput("busy during ignored start", 64'(busy), 64'(1));

        // Reset ten cycles into a divide aborts it without a done pulse
        applyStimulus("DIVU aborted",    OP_DIVU,   32'd1000,     32'd3,        5'd15, 32'd0,       33, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("busy before abort", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy), 64'(0));
        checkOutput("abort done", 64'(done), 64'(0));
        checkOutput("abort result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus("DIVU 1000/3",     OP_DIVU,   32'd1000,     32'd3,        5'd16, 32'd333,     33, 1'b1);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard drained", 64'(sbq.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register unit.
- Consumes the ru1/ru2 read operands plus funct3 and the destination register index.
- Produces a 32-bit result with a one-cycle done pulse and a write-back tag.
- The tag drives the register unit's rd/rudw/ruwr write port.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- ru1  input  XLEN  operand A (rs1 value)
- ru2  input  XLEN  operand B (rs2 value)
- rd_i  input  5  destination register index
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse; result valid that cycle
- result  output  XLEN  operation result, held until the next accepted start
- rd_o  output  5  captured rd_i, valid with done
- ruwr_o  output  1  done && (rd_o != 0); write enable to the register unit

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy=0, done=0, result=0, rd_o=0, ruwr_o=0; all internal accumulators cleared.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 captures ru1, ru2, funct3, rd_i and sets busy=1.
  - funct3[2]=0 goes to MUL; funct3[2]=1 goes to DIV.
  - A DIV-class special case goes directly to FIN.
- MUL:
  - Shift-add over operand magnitudes, 2*XLEN-bit product, XLEN iterations, then FIN.
  - Sign treatment: MUL/MULH signed×signed; MULHSU signed A × unsigned B; MULHU unsigned×unsigned.
  - Product is negated when the sign flag is set.
  - MUL returns the low XLEN bits; the other three return the high XLEN bits.
- DIV:
  - Restoring division on magnitudes, XLEN iterations, then FIN.
  - Quotient sign = sign(A) xor sign(B), signed ops only.
  - Remainder sign = sign(A), signed ops only.
- Special cases, decided at accept:
  - B=0: quotient = all ones; remainder = A.
  - Signed A=0x80000000, B=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- FIN:
  - result registered, done=1, ruwr_o per rule; next edge returns to IDLE with busy=0.
- Latency, counting the accepting edge as edge 0:
  - Normal ops: done is high in the cycle following edge XLEN+1 (33 for XLEN=32).
  - Special cases: done is high after edge 1.
- Back-to-back: start may be asserted in the cycle done is high. It is ignored because state is FIN; the next accept happens in IDLE one cycle later.
- start is ignored while busy; captured operands never change mid-operation.
- Reset mid-operation aborts immediately: no done pulse, no write.
- done and ruwr_o are never asserted for more than one cycle per accepted start.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: MUL-class ops with ru1==0 or ru2==0 go directly to FIN with result 0 (done after edge 1).
- Not defined: these ops take the full XLEN-iteration latency with identical result values.

Decomposition:
- Package muldiv_pkg holds:
  - enum op_e for the eight funct3 encodings
  - enum state_e {IDLE, MUL, DIV, FIN}
  - XLEN-derived localparams
  - DIV_BY_ZERO_Q constant (all ones)
- One natural sub-module: muldiv_sign_adj, a combinational conditional-negate/absolute-value helper. It is instantiated for operand magnitudes and for the result fix-up.

Test Plan:
- MUL ru1=7, ru2=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; done exactly 33 cycles after accept; ruwr_o=1 with rd_i=5 -> rd_o=5.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Edge cases, each with done after 1 cycle:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start re-asserted with other operands while busy -> ignored, original result returned.
- rd_i=0 -> done=1 but ruwr_o=0.
- Reset pulsed 10 cycles into a DIV -> busy=0, done never pulses; next start completes correctly.
- With MULDIV_EARLY_OUT_EN: MUL 0×12345 -> 0, done after 1 cycle. Without the macro -> 0 after 33 cycles.
